// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the conv window feeder and the conv unit image port:
// pixel width, window element count, width helper, window layout index.
package conv_window_feeder_pkg;

    localparam int unsigned PIX_WIDTH = 16;

    // Number of elements in an F x F window.
    function automatic int unsigned win_elems(input int unsigned f);
        return f * f;
    endfunction

    // Ceiling log2, never narrower than one bit so counters stay declarable.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

    // Flattened element index: row r (0 = top), column c (0 = leftmost).
    function automatic int unsigned elem_idx(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned f);
        return r * f + c;
    endfunction

    typedef enum logic {
        WIN_EMPTY = 1'b0,
        WIN_FULL  = 1'b1
    } win_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// Raster line buffer of (F-1)*W+F pixels exposing an F x F window of taps.
// The taps show the contents as they will be after the pending shift, so the
// newest pixel is taken straight from pix_i and only the older entries are
// held in registers.
module conv_line_buffer
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIX_WIDTH,
    parameter int unsigned F          = 5,
    parameter int unsigned W          = 32
) (
    input  logic                                clk_i,
    input  logic                                shift_en_i,
    input  logic [DATA_WIDTH-1:0]               pix_i,
    output logic [win_elems(F)*DATA_WIDTH-1:0]  taps_o
);

    localparam int unsigned DEPTH = (F - 1) * W + F;

    // Entry 0 of the full buffer is pix_i itself; sr_q[j] holds entry j+1.
    logic [DATA_WIDTH-1:0] sr_q [DEPTH-1];

    function automatic int unsigned tap_pos(input int unsigned r,
                                            input int unsigned c);
        return (F - 1 - r) * W + (F - 1 - c);
    endfunction

    // Shift one accepted pixel in at the head.
    always_ff @(posedge clk_i) begin
        if (shift_en_i) begin
            sr_q[0] <= pix_i;
            for (int unsigned j = 1; j < DEPTH - 1; j++) begin
                sr_q[j] <= sr_q[j-1];
            end
        end
    end

    // Gather the window taps into the flattened conv-unit layout.
    always_comb begin
        taps_o = '0;
        for (int unsigned r = 0; r < F; r++) begin
            for (int unsigned c = 0; c < F; c++) begin
                if (tap_pos(r, c) == 0) begin
                    taps_o[elem_idx(r, c, F)*DATA_WIDTH +: DATA_WIDTH] = pix_i;
                end else begin
                    taps_o[elem_idx(r, c, F)*DATA_WIDTH +: DATA_WIDTH] =
                        sr_q[tap_pos(r, c) - 1];
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Builds stride-1 F x F windows from a raster pixel stream and hands them to
// the conv controller over a valid/ready handshake. One window register; the
// pixel input stalls while that register holds an unconsumed window.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIX_WIDTH,
    parameter int unsigned F          = 5,
    parameter int unsigned W          = 32,
    parameter int unsigned H          = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               pix_in,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    output logic [win_elems(F)*DATA_WIDTH-1:0]  window,
    output logic                                win_valid,
    input  logic                                win_ready,
    output logic [clog2_min1(H)-1:0]            win_row,
    output logic [clog2_min1(W)-1:0]            win_col,
    output logic                                frame_done
);

    localparam int unsigned ROW_W = clog2_min1(H);
    localparam int unsigned COL_W = clog2_min1(W);
    localparam int unsigned WIN_W = win_elems(F) * DATA_WIDTH;

    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(F - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(F - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);

    win_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [WIN_W-1:0]  window_q, window_d;
    logic [ROW_W-1:0]  win_row_q, win_row_d;
    logic [COL_W-1:0]  win_col_q, win_col_d;
    logic              frame_done_q, frame_done_d;

    logic              accept;
    logic              trigger;
    logic              last_pix;
    logic [WIN_W-1:0]  taps;

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .F          (F),
        .W          (W)
    ) u_line_buffer (
        .clk_i      (clk),
        .shift_en_i (accept),
        .pix_i      (pix_in),
        .taps_o     (taps)
    );

    // Handshake and window-completion decode for the current cycle.
    always_comb begin
        pix_ready = (state_q == WIN_EMPTY) || win_ready;
        accept    = pix_valid && pix_ready;
        last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        trigger   = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    end

    // Window register occupancy: a new window always wins over consumption.
    always_comb begin
        state_d = state_q;
        if (trigger) begin
            state_d = WIN_FULL;
        end else if ((state_q == WIN_FULL) && win_ready) begin
            state_d = WIN_EMPTY;
        end
    end

    // Raster position counters, window capture and end-of-frame pulse.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        window_d     = window_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        if (accept) begin
            if (last_pix) begin
                row_d        = '0;
                col_d        = '0;
                frame_done_d = 1'b1;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (trigger) begin
            window_d  = taps;
            win_row_d = row_q - ROW_FIRST;
            win_col_d = col_q - COL_FIRST;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WIN_EMPTY;
            row_q        <= '0;
            col_q        <= '0;
            window_q     <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            window_q     <= window_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = (state_q == WIN_FULL);
    assign window     = window_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: a scoreboard built from the raster image and
// window definition, plus directed checks for latency, backpressure, reset
// and a 5x5 fill case on a second instance.
module tb_conv_window_feeder;

    localparam int F  = 3;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 16;
    localparam int NB = F * F * DW;

    localparam logic [399:0] FILL_WIN = {25{16'h4400}};

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [NB-1:0] window;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic [2:0]    win_row;
    logic [2:0]    win_col;
    logic          frame_done;

    logic [DW-1:0] f_pix_in = 16'h4400;
    logic          f_pix_valid = 1'b0;
    logic          f_pix_ready;
    logic [399:0]  f_window;
    logic          f_win_valid;
    logic          f_win_ready = 1'b1;
    logic [2:0]    f_win_row;
    logic [2:0]    f_win_col;
    logic          f_frame_done;

    conv_window_feeder #(.DATA_WIDTH(DW), .F(F), .W(W), .H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    conv_window_feeder #(.DATA_WIDTH(16), .F(5), .W(5), .H(5)) dut_fill (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (f_pix_in),
        .pix_valid  (f_pix_valid),
        .pix_ready  (f_pix_ready),
        .window     (f_window),
        .win_valid  (f_win_valid),
        .win_ready  (f_win_ready),
        .win_row    (f_win_row),
        .win_col    (f_win_col),
        .frame_done (f_frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // 0: always ready, 1: random ready, 2: not ready
    int rdy_mode = 0;
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = ($urandom_range(0, 3) != 0);
            default: win_ready = 1'b0;
        endcase
    end

    // Reference model: image array, expected-window queue, expected valid/done.
    typedef struct {
        logic [NB-1:0] win;
        int            row;
        int            col;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    bit            exp_valid = 0;
    bit            exp_fd = 0;
    bit            trig;
    int            win_cnt = 0;
    int            fd_cnt = 0;
    logic [NB-1:0] rec_win [256];
    int            rec_row [256];
    int            rec_col [256];

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_valid = 0;
            exp_fd    = 0;
            m_row     = 0;
            m_col     = 0;
        end else begin
            chk("win_valid", win_valid, exp_valid);
            chk("pix_ready", pix_ready, !exp_valid || win_ready);
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("window", window, e.win);
                    chk("win_row", win_row, e.row);
                    chk("win_col", win_col, e.col);
                end
                if (win_cnt < 256) begin
                    rec_win[win_cnt] = window;
                    rec_row[win_cnt] = int'(win_row);
                    rec_col[win_cnt] = int'(win_col);
                end
                win_cnt++;
            end
            trig   = 0;
            exp_fd = 0;
            if (pix_valid && pix_ready) begin
                img[m_row][m_col] = pix_in;
                if (m_row >= F - 1 && m_col >= F - 1) begin
                    e.row = m_row - (F - 1);
                    e.col = m_col - (F - 1);
                    for (int r = 0; r < F; r++)
                        for (int c = 0; c < F; c++)
                            e.win[(r*F+c)*DW +: DW] = img[e.row + r][e.col + c];
                    exp_q.push_back(e);
                    trig = 1;
                end
                if (m_row == H - 1 && m_col == W - 1) begin
                    exp_fd = 1;
                    m_row  = 0;
                    m_col  = 0;
                end else if (m_col == W - 1) begin
                    m_col = 0;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
            exp_valid = trig || (exp_valid && !win_ready);
        end
    end

    // Stimulus-side bookkeeping.
    int acc_cnt = 0;
    int first_acc = -1;
    int stalls = 0;

    task automatic send_pixel(input logic [DW-1:0] v, input bit rand_valid);
        bit done;
        int guard;
        done  = 0;
        guard = 0;
        while (!done) begin
            pix_in    = v;
            pix_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (win_valid && first_acc < 0) first_acc = acc_cnt;
            if (pix_valid && pix_ready) begin
                done = 1;
                acc_cnt++;
            end else if (pix_valid) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 300) begin
                chk("pixel_accept_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int kind, input bit rand_valid);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel((kind == 0) ? 16'((r << 4) | c) : 16'($urandom), rand_valid);
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        bit idle;
        idle      = 0;
        pix_valid = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(posedge clk);
            #1;
            if (!win_valid && exp_q.size() == 0) idle = 1;
        end
        if (!idle) chk("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fd0;
        logic [NB-1:0] tw;
        logic [NB-1:0] held;
        logic [399:0] cap;
        int sent;
        int nwin;
        int nfd;
        int rc;
        int cc;
        bit seen;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_window", window, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_fill_valid", f_win_valid, 0);
        @(posedge clk);
        #1;

        // Basic frame, continuous flow
        base = win_cnt; fd0 = fd_cnt; first_acc = -1; acc_cnt = 0; stalls = 0;
        send_frame(0, 0);
        drain();
        chk("basic_first_latency", first_acc, 19);
        chk("basic_nwin", win_cnt - base, 36);
        tw = rec_win[base];
        chk("basic_first_e0", tw[0*DW +: DW], 16'h0000);
        chk("basic_first_e4", tw[4*DW +: DW], 16'h0011);
        chk("basic_first_e8", tw[8*DW +: DW], 16'h0022);
        chk("basic_first_row", rec_row[base], 0);
        chk("basic_first_col", rec_col[base], 0);
        tw = rec_win[base + 35];
        chk("basic_last_e8", tw[8*DW +: DW], 16'h0077);
        chk("basic_last_row", rec_row[base + 35], 5);
        chk("basic_last_col", rec_col[base + 35], 5);
        chk("basic_no_stall", stalls, 0);
        chk("basic_frame_done", fd_cnt - fd0, 1);

        // Backpressure after the first window
        base = win_cnt;
        fork
            send_frame(0, 0);
            begin
                seen = 0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge clk);
                    if (win_valid) seen = 1;
                end
                if (!seen) chk("bp_wait_timeout", 0, 1);
                rdy_mode = 2;
                @(posedge clk);
                #2;
                held = window;
                chk("bp_held_col", win_col, 1);
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_window_stable", window, held);
                    chk("bp_pix_ready_low", pix_ready, 0);
                    chk("bp_valid_held", win_valid, 1);
                end
                rdy_mode = 0;
            end
        join
        drain();
        chk("bp_nwin", win_cnt - base, 36);
        chk("bp_first_col", rec_col[base], 0);
        chk("bp_resume_row", rec_row[base + 1], 0);
        chk("bp_resume_col", rec_col[base + 1], 1);

        // Random flow over two frames
        base = win_cnt; fd0 = fd_cnt;
        rdy_mode = 1;
        send_frame(1, 1);
        send_frame(1, 1);
        rdy_mode = 0;
        drain();
        chk("rand_nwin", win_cnt - base, 72);
        chk("rand_f1_last_row", rec_row[base + 35], 5);
        chk("rand_f1_last_col", rec_col[base + 35], 5);
        chk("rand_f2_first_row", rec_row[base + 36], 0);
        chk("rand_f2_first_col", rec_col[base + 36], 0);
        chk("rand_frame_done", fd_cnt - fd0, 2);

        // Reset after pixel (4,3) with a window pending
        for (int i = 0; i < 36; i++)
            send_pixel(16'(((i / W) << 4) | (i % W)), 0);
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_win_valid", win_valid, 0);
        chk("rst_mid_pix_ready", pix_ready, 1);
        @(posedge clk);
        #1;
        base = win_cnt; first_acc = -1; acc_cnt = 0;
        send_frame(0, 0);
        drain();
        chk("rst_mid_first_latency", first_acc, 19);
        tw = rec_win[base];
        chk("rst_mid_first_e0", tw[0*DW +: DW], 16'h0000);
        chk("rst_mid_first_row", rec_row[base], 0);
        chk("rst_mid_first_col", rec_col[base], 0);
        chk("rst_mid_nwin", win_cnt - base, 36);

        // Fill case on the 5x5 instance
        sent = 0; nwin = 0; nfd = 0; cap = '0; rc = -1; cc = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            f_pix_valid = (sent < 25);
            f_pix_in    = 16'h4400;
            @(negedge clk);
            if (f_pix_valid && f_pix_ready) sent++;
            if (f_win_valid) begin
                nwin++;
                cap = f_window;
                rc  = int'(f_win_row);
                cc  = int'(f_win_col);
            end
            if (f_frame_done) nfd++;
            @(posedge clk);
            #1;
        end
        f_pix_valid = 1'b0;
        chk("fill_sent", sent, 25);
        chk("fill_nwin", nwin, 1);
        chk("fill_window", cap, FILL_WIN);
        chk("fill_row", rc, 0);
        chk("fill_col", cc, 0);
        chk("fill_frame_done", nfd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
